// File: rtl/booth_pp_accumulator_if.sv
// Operand, product and Booth-encoder signal bundle for booth_pp_accumulator.
// The slave side is the accumulator; the master side is its environment (source, sink, encoder).
interface booth_pp_accumulator_if #(
    parameter int unsigned WIDTH = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;

    logic [WIDTH-1:0]     enc_a;
    logic [2:0]           enc_sel;
    logic [WIDTH:0]       enc_p;
    logic                 enc_s;
    logic                 enc_e;

    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_p;

    modport master (
        output in_valid, in_a, in_b, out_ready, enc_p, enc_s, enc_e,
        input  in_ready, out_valid, out_p, enc_a, enc_sel
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready, enc_p, enc_s, enc_e,
        output in_ready, out_valid, out_p, enc_a, enc_sel
    );
endinterface

// File: rtl/booth_pp_accumulator.sv
// Sequential radix-4 Booth multiply: steps the external encoder through WIDTH/2 windows and
// accumulates one sign-extension-optimised partial-product row per cycle.
module booth_pp_accumulator #(
    parameter int unsigned WIDTH = 16
) (
    input logic                   clk,
    input logic                   rst_n,
    booth_pp_accumulator_if.slave bus
);
    localparam int unsigned Rows  = WIDTH / 2;
    localparam int unsigned IdxW  = (Rows > 1) ? $clog2(Rows) : 1;
    localparam int unsigned ProdW = 2 * WIDTH;
    localparam int unsigned RowW  = WIDTH + 4;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(Rows - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [ProdW-1:0] acc_q, acc_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [WIDTH:0]   b_ext;
    logic [2:0]       sel;
    logic [RowW-1:0]  row_pre;
    logic [RowW-1:0]  row_raw;
    logic [ProdW-1:0] row;

    // Window {b[2i+1], b[2i], b[2i-1]} with an implicit zero below bit 0.
    always_comb begin
        b_ext = {b_q, 1'b0};
        sel   = 3'b000;
        if (state_q == StRun) begin
            sel = b_ext[{idx_q, 1'b0} +: 3];
        end
    end

    // Prefixes replace full sign extension; their constant offsets cancel modulo 2^(2*WIDTH).
    always_comb begin
        if (idx_q == '0) begin
            row_pre = {bus.enc_e, ~bus.enc_e, ~bus.enc_e, bus.enc_p};
        end else begin
            row_pre = {1'b0, 1'b1, bus.enc_e, bus.enc_p};
        end
        row_raw = row_pre + RowW'(bus.enc_s);
        row     = ProdW'(row_raw) << {idx_q, 1'b0};
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid && in_ready_q) begin
                    a_d        = bus.in_a;
                    b_d        = bus.in_b;
                    acc_d      = '0;
                    idx_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = StRun;
                end
            end
            StRun: begin
                acc_d = acc_q + row;
                idx_d = idx_q + IdxW'(1);
                if (idx_q == LastIdx) begin
                    idx_d       = '0;
                    out_valid_d = 1'b1;
                    state_d     = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d     = StIdle;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_p     = acc_q;
    assign bus.enc_sel   = sel;
    assign bus.enc_a     = a_q;

endmodule

// File: tb/tb_booth_pp_accumulator.sv
// Bench for booth_pp_accumulator: behavioural Booth encoder plus directed and random
// multiplies checked against plain signed multiplication.
module tb_booth_pp_accumulator;
    localparam int unsigned WIDTH   = 16;
    localparam int unsigned NumRand = 2000;

    logic        clk = 1'b0;
    logic        rst_n;
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [31:0] exp_q[$];
    int unsigned got_cnt = 0;

    booth_pp_accumulator_if #(.WIDTH(WIDTH)) bus ();

    booth_pp_accumulator #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Encoder: 000/111 zero, 001/010 +A, 011 +2A, 100 -2A, 101/110 -A; negatives as ~mag + S.
    logic [WIDTH:0] enc_mag;
    logic           enc_neg;
    logic [WIDTH:0] enc_p_m;
    always_comb begin
        enc_mag = '0;
        enc_neg = 1'b0;
        case (bus.enc_sel)
            3'b001, 3'b010: enc_mag = {bus.enc_a[WIDTH-1], bus.enc_a};
            3'b011:         enc_mag = {bus.enc_a, 1'b0};
            3'b100: begin
                enc_mag = {bus.enc_a, 1'b0};
                enc_neg = 1'b1;
            end
            3'b101, 3'b110: begin
                enc_mag = {bus.enc_a[WIDTH-1], bus.enc_a};
                enc_neg = 1'b1;
            end
            default: ;
        endcase
        enc_p_m = enc_neg ? ~enc_mag : enc_mag;
    end
    assign bus.enc_p = enc_p_m;
    assign bus.enc_s = enc_neg;
    assign bus.enc_e = ~enc_p_m[WIDTH];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_prod(input logic [15:0] a, input logic [15:0] b);
        int ai;
        int bi;
        ai = int'($signed(a));
        bi = int'($signed(b));
        return 32'(ai * bi);
    endfunction

    function automatic logic [2:0] ref_sel(input logic [15:0] b, input int k);
        logic [16:0] e;
        e = {b, 1'b0};
        return e[2*k +: 3];
    endfunction

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'h0001;
            2:       return 16'hFFFF;
            3:       return 16'h7FFF;
            4:       return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic mult(input logic [15:0] a, input logic [15:0] b, output logic [31:0] p);
        int n;
        @(negedge clk);
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        p = bus.out_valid ? bus.out_p : 'x;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [31:0] p;
        int n;

        rst_n         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_p", 64'(bus.out_p), 64'd0);
        check("rst_enc_sel", 64'(bus.enc_sel), 64'd0);
        check("rst_enc_a", 64'(bus.enc_a), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 3 * 5 with the window sequence and exact latency
        @(negedge clk);
        bus.in_a = 16'd3;
        bus.in_b = 16'd5;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        check("idle_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_a = 16'hDEAD;
        bus.in_b = 16'hBEEF;
        for (int k = 0; k < 8; k++) begin
            check("sel_3x5", 64'(bus.enc_sel), 64'(ref_sel(16'd5, k)));
            check("run_no_valid", 64'(bus.out_valid), 64'd0);
            @(negedge clk);
        end
        check("lat_valid", 64'(bus.out_valid), 64'd1);
        check("p_3x5", 64'(bus.out_p), 64'h0000000F);
        check("done_sel", 64'(bus.enc_sel), 64'd0);
        check("enc_a_latched", 64'(bus.enc_a), 64'd3);
        @(negedge clk);
        check("back_idle_valid", 64'(bus.out_valid), 64'd0);
        check("back_idle_ready", 64'(bus.in_ready), 64'd1);

        mult(16'hFFFF, 16'hFFFF, p);
        check("p_m1xm1", 64'(p), 64'h00000001);
        mult(16'h8000, 16'h8000, p);
        check("p_minxmin", 64'(p), 64'h40000000);
        mult(16'h7FFF, 16'h8000, p);
        check("p_maxxmin", 64'(p), 64'hC0008000);
        mult(16'h0000, 16'h1234, p);
        check("p_zero", 64'(p), 64'h00000000);

        // Backpressure: product held, operands ignored, single transfer
        @(negedge clk);
        bus.in_a = 16'hFFF9;
        bus.in_b = 16'd9;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_a = 16'($urandom);
            bus.in_b = 16'($urandom);
            check("bp_valid", 64'(bus.out_valid), 64'd1);
            check("bp_p", 64'(bus.out_p), 64'hFFFFFFC1);
            check("bp_in_ready", 64'(bus.in_ready), 64'd0);
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("bp_one_xfer", 64'(bus.out_valid), 64'd0);
        check("bp_no_accept", 64'(bus.in_ready), 64'd1);

        // Reset during iteration 3, then accept right at reset release
        @(negedge clk);
        bus.in_a = 16'd100;
        bus.in_b = 16'd77;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_valid", 64'(bus.out_valid), 64'd0);
        check("abort_p", 64'(bus.out_p), 64'd0);
        check("abort_sel", 64'(bus.enc_sel), 64'd0);
        check("abort_ready", 64'(bus.in_ready), 64'd1);
        bus.in_a = 16'd2;
        bus.in_b = 16'd2;
        bus.in_valid = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("rel_accept", 64'(bus.in_ready), 64'd0);
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("rel_latency", 64'(n), 64'd8);
        check("rel_p_2x2", 64'(bus.out_p), 64'd4);
        @(negedge clk);
        @(negedge clk);

        // Random traffic with gaps on both sides
        fork
            begin
                for (int t = 0; t < NumRand; t++) begin
                    logic [15:0] a;
                    logic [15:0] b;
                    int w;
                    a = pick();
                    b = pick();
                    bus.in_a = a;
                    bus.in_b = b;
                    bus.in_valid = 1'b1;
                    w = 0;
                    while (!bus.in_ready && w < 200) begin
                        @(negedge clk);
                        w++;
                    end
                    if (!bus.in_ready) begin
                        check("rand_accept_timeout", 64'd0, 64'd1);
                        break;
                    end
                    exp_q.push_back(ref_prod(a, b));
                    @(negedge clk);
                    bus.in_valid = 1'b0;
                    repeat ($urandom_range(0, 3)) begin
                        bus.in_a = 16'($urandom);
                        bus.in_b = 16'($urandom);
                        @(negedge clk);
                    end
                end
                bus.in_valid = 1'b0;
            end
            begin
                int cyc;
                cyc = 0;
                while (got_cnt < NumRand && cyc < 40000) begin
                    @(negedge clk);
                    cyc++;
                    bus.out_ready = ($urandom_range(0, 9) < 7);
                    if (bus.out_valid && bus.out_ready) begin
                        if (exp_q.size() == 0) begin
                            check("rand_dup", 64'(bus.out_p), 64'hDEAD_0000_0000);
                        end else begin
                            check("rand_prod", 64'(bus.out_p), 64'(exp_q.pop_front()));
                        end
                        got_cnt++;
                    end
                end
            end
        join
        check("rand_count", 64'(got_cnt), 64'(NumRand));
        check("rand_leftover", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
